// File: rtl/tone_period_detector.sv
// Measures the rise-to-rise period of an incoming square-wave tone in clk cycles,
// classifies it against a base period (same / octave down / octave up), and flags lock and silence.
module tone_period_detector #(
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 16'hFFFF,
    parameter int TOL_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             tone_i,
    input  logic [CNT_W-1:0] base_period,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic [1:0]       octave_o,
    output logic             lock_o,
    output logic             silent_o
);

    localparam int               EXT_W       = CNT_W + 2;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    localparam logic [1:0] OCT_NONE = 2'b00;
    localparam logic [1:0] OCT_SAME = 2'b01;
    localparam logic [1:0] OCT_DOWN = 2'b10;
    localparam logic [1:0] OCT_UP   = 2'b11;

    typedef enum logic [1:0] {IDLE, MEASURE, SILENT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] prev_period, prev_next;
    logic             have_prev, have_prev_next;
    logic [CNT_W-1:0] period_next;
    logic             valid_next;
    logic [1:0]       octave_next;
    logic             lock_next;
    logic             silent_next;

    logic             s1, s2, s3;
    logic             rise;

    logic [EXT_W-1:0] p_ext, b_ext, tol_ext, prev_ext;
    logic [1:0]       octave_class;
    logic             lock_hit;

    function automatic logic [EXT_W-1:0] abs_diff(input logic [EXT_W-1:0] a,
                                                  input logic [EXT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tone_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Two extra bits keep 2*B and 2*tol from overflowing.
    always_comb begin
        p_ext        = {2'b00, cnt};
        b_ext        = {2'b00, base_period};
        tol_ext      = b_ext >> TOL_SHIFT;
        prev_ext     = {2'b00, prev_period};
        octave_class = OCT_NONE;
        if (base_period == '0)
            octave_class = OCT_NONE;
        else if (abs_diff(p_ext, b_ext) <= tol_ext)
            octave_class = OCT_SAME;
        else if (abs_diff(p_ext, b_ext << 1) <= (tol_ext << 1))
            octave_class = OCT_DOWN;
        else if (abs_diff(p_ext, b_ext >> 1) <= (tol_ext >> 1))
            octave_class = OCT_UP;
        lock_hit = have_prev && (abs_diff(p_ext, prev_ext) <= (prev_ext >> TOL_SHIFT));
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        period_next    = period_o;
        valid_next     = 1'b0;
        octave_next    = octave_o;
        lock_next      = lock_o;
        silent_next    = silent_o;
        prev_next      = prev_period;
        have_prev_next = have_prev;
        if (!ena) begin
            state_next     = IDLE;
            cnt_next       = '0;
            octave_next    = OCT_NONE;
            lock_next      = 1'b0;
            silent_next    = 1'b0;
            have_prev_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_next = MEASURE;
                        cnt_next   = CNT_W'(1);
                    end else if (cnt == TIMEOUT_CNT) begin
                        state_next     = SILENT;
                        silent_next    = 1'b1;
                        lock_next      = 1'b0;
                        octave_next    = OCT_NONE;
                        have_prev_next = 1'b0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    // A rise coinciding with the timeout still counts as a full period.
                    if (rise) begin
                        period_next    = cnt;
                        valid_next     = 1'b1;
                        cnt_next       = CNT_W'(1);
                        octave_next    = octave_class;
                        lock_next      = lock_hit;
                        prev_next      = cnt;
                        have_prev_next = 1'b1;
                    end else if (cnt == TIMEOUT_CNT) begin
                        state_next     = SILENT;
                        silent_next    = 1'b1;
                        lock_next      = 1'b0;
                        octave_next    = OCT_NONE;
                        have_prev_next = 1'b0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                SILENT: begin
                    if (rise) begin
                        state_next  = MEASURE;
                        cnt_next    = CNT_W'(1);
                        silent_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            prev_period    <= '0;
            have_prev      <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
            octave_o       <= OCT_NONE;
            lock_o         <= 1'b0;
            silent_o       <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            prev_period    <= prev_next;
            have_prev      <= have_prev_next;
            period_o       <= period_next;
            period_valid_o <= valid_next;
            octave_o       <= octave_next;
            lock_o         <= lock_next;
            silent_o       <= silent_next;
        end
    end

endmodule

// File: tb/tb_tone_period_detector.sv
// Directed bench for tone_period_detector: period measurement, classification, lock, silence, enable and reset.
module tb_tone_period_detector;

    localparam int CNT_W     = 16;
    localparam int TIMEOUT   = 1000;
    localparam int TOL_SHIFT = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             tone_i;
    logic [CNT_W-1:0] base_period;
    logic [CNT_W-1:0] period_o;
    logic             period_valid_o;
    logic [1:0]       octave_o;
    logic             lock_o;
    logic             silent_o;

    int total = 0;
    int bad   = 0;

    int         vp_q[$];
    logic [1:0] oc_q[$];
    logic       lk_q[$];

    tone_period_detector #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .TOL_SHIFT(TOL_SHIFT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .tone_i        (tone_i),
        .base_period   (base_period),
        .period_o      (period_o),
        .period_valid_o(period_valid_o),
        .octave_o      (octave_o),
        .lock_o        (lock_o),
        .silent_o      (silent_o)
    );

    always #5 clk = ~clk;

    // Log every valid pulse so scenario tasks can inspect the sequence.
    always @(posedge clk) begin
        #1;
        if (period_valid_o === 1'b1) begin
            vp_q.push_back(int'(period_o));
            oc_q.push_back(octave_o);
            lk_q.push_back(lock_o);
        end
    end

    task automatic clear_log();
        vp_q.delete();
        oc_q.delete();
        lk_q.delete();
    endtask

    // Starts and ends on a falling clk edge; each period begins with a rise.
    task automatic run_periods(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            tone_i = 1'b1;
            repeat (p / 2) @(negedge clk);
            tone_i = 1'b0;
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; tone_i = 1'b0; base_period = 16'd100;
        #23;
        total++; if (period_o !== 16'd0) begin bad++; $display("[TB] FAIL reset_period got=%0d want=0", period_o); end
        total++; if (period_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", period_valid_o); end
        total++; if (octave_o !== 2'b00) begin bad++; $display("[TB] FAIL reset_octave got=%b want=00", octave_o); end
        total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_lock got=%b want=0", lock_o); end
        total++; if (silent_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_silent got=%b want=0", silent_o); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (500) @(negedge clk);
        total++; if (vp_q.size() != 0) begin bad++; $display("[TB] FAIL idle_pulses got=%0d want=0", vp_q.size()); end
        total++; if (silent_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_silent got=%b want=0", silent_o); end
    endtask

    task automatic test_basic();
        clear_log();
        run_periods(100, 1);
        total++; if (vp_q.size() != 0) begin bad++; $display("[TB] FAIL first_rise_pulses got=%0d want=0", vp_q.size()); end
        tone_i = 1'b1;
        @(posedge clk); #1;
        total++; if (period_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL latency_edge1 got=%b want=0", period_valid_o); end
        @(posedge clk); #1;
        total++; if (period_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL latency_edge2 got=%b want=0", period_valid_o); end
        @(posedge clk); #1;
        total++; if (period_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL latency_edge3 got=%b want=1", period_valid_o); end
        total++; if (period_o !== 16'd100) begin bad++; $display("[TB] FAIL basic_period got=%0d want=100", period_o); end
        total++; if (octave_o !== 2'b01) begin bad++; $display("[TB] FAIL basic_octave got=%b want=01", octave_o); end
        total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_lock0 got=%b want=0", lock_o); end
        repeat (48) @(negedge clk);
        tone_i = 1'b0;
        repeat (50) @(negedge clk);
        run_periods(100, 1);
        total++; if (vp_q.size() != 2) begin bad++; $display("[TB] FAIL basic_pulses got=%0d want=2", vp_q.size()); end
        if (vp_q.size() >= 2) begin
            total++; if (vp_q[1] != 100) begin bad++; $display("[TB] FAIL basic_period2 got=%0d want=100", vp_q[1]); end
            total++; if (lk_q[1] !== 1'b1) begin bad++; $display("[TB] FAIL basic_lock1 got=%b want=1", lk_q[1]); end
        end
    endtask

    task automatic test_octaves();
        int         per[3] = '{200, 50, 150};
        logic [1:0] exp_oc[3] = '{2'b10, 2'b11, 2'b00};
        for (int k = 0; k < 3; k++) begin
            clear_log();
            run_periods(per[k], 3);
            total++; if (vp_q.size() != 3) begin bad++; $display("[TB] FAIL oct_pulses p=%0d got=%0d want=3", per[k], vp_q.size()); end
            if (vp_q.size() >= 3) begin
                total++; if (vp_q[1] != per[k]) begin bad++; $display("[TB] FAIL oct_period got=%0d want=%0d", vp_q[1], per[k]); end
                total++; if (oc_q[1] !== exp_oc[k]) begin bad++; $display("[TB] FAIL oct_class1 p=%0d got=%b want=%b", per[k], oc_q[1], exp_oc[k]); end
                total++; if (lk_q[1] !== 1'b0) begin bad++; $display("[TB] FAIL oct_lockdrop p=%0d got=%b want=0", per[k], lk_q[1]); end
                total++; if (oc_q[2] !== exp_oc[k]) begin bad++; $display("[TB] FAIL oct_class2 p=%0d got=%b want=%b", per[k], oc_q[2], exp_oc[k]); end
                total++; if (lk_q[2] !== 1'b1) begin bad++; $display("[TB] FAIL oct_relock p=%0d got=%b want=1", per[k], lk_q[2]); end
            end
        end
    endtask

    task automatic test_tolerance();
        int         per[6] = '{112, 113, 224, 225, 56, 57};
        logic [1:0] exp_oc[6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
        for (int k = 0; k < 6; k++) begin
            clear_log();
            run_periods(per[k], 2);
            total++; if (vp_q.size() != 2) begin bad++; $display("[TB] FAIL tol_pulses p=%0d got=%0d want=2", per[k], vp_q.size()); end
            if (vp_q.size() >= 2) begin
                total++; if (vp_q[1] != per[k]) begin bad++; $display("[TB] FAIL tol_period got=%0d want=%0d", vp_q[1], per[k]); end
                total++; if (oc_q[1] !== exp_oc[k]) begin bad++; $display("[TB] FAIL tol_class p=%0d got=%b want=%b", per[k], oc_q[1], exp_oc[k]); end
            end
        end
    endtask

    task automatic test_silence();
        run_periods(100, 3);
        clear_log();
        tone_i = 1'b1;
        repeat (50) @(negedge clk);
        tone_i = 1'b0;
        repeat (952) @(posedge clk);
        #1;
        total++; if (silent_o !== 1'b0) begin bad++; $display("[TB] FAIL silent_early got=%b want=0", silent_o); end
        @(posedge clk); #1;
        total++; if (silent_o !== 1'b1) begin bad++; $display("[TB] FAIL silent_set got=%b want=1", silent_o); end
        total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL silent_lock got=%b want=0", lock_o); end
        total++; if (octave_o !== 2'b00) begin bad++; $display("[TB] FAIL silent_octave got=%b want=00", octave_o); end
        total++; if (period_o !== 16'd100) begin bad++; $display("[TB] FAIL silent_period_hold got=%0d want=100", period_o); end
        @(negedge clk);
        clear_log();
        run_periods(100, 1);
        total++; if (vp_q.size() != 0) begin bad++; $display("[TB] FAIL restart_pulses got=%0d want=0", vp_q.size()); end
        total++; if (silent_o !== 1'b0) begin bad++; $display("[TB] FAIL restart_silent got=%b want=0", silent_o); end
        run_periods(100, 1);
        total++; if (vp_q.size() != 1) begin bad++; $display("[TB] FAIL restart_pulses2 got=%0d want=1", vp_q.size()); end
        if (vp_q.size() >= 1) begin
            total++; if (vp_q[0] != 100) begin bad++; $display("[TB] FAIL restart_period got=%0d want=100", vp_q[0]); end
            total++; if (lk_q[0] !== 1'b0) begin bad++; $display("[TB] FAIL restart_lock got=%b want=0", lk_q[0]); end
        end
        clear_log();
        run_periods(1000, 1);
        run_periods(100, 1);
        total++; if (vp_q.size() != 2) begin bad++; $display("[TB] FAIL edge_timeout_pulses got=%0d want=2", vp_q.size()); end
        if (vp_q.size() >= 2) begin
            total++; if (vp_q[1] != 1000) begin bad++; $display("[TB] FAIL edge_timeout_period got=%0d want=1000", vp_q[1]); end
        end
        total++; if (silent_o !== 1'b0) begin bad++; $display("[TB] FAIL edge_timeout_silent got=%b want=0", silent_o); end
    endtask

    task automatic test_enable();
        run_periods(100, 2);
        tone_i = 1'b1;
        repeat (30) @(negedge clk);
        ena = 1'b0;
        @(posedge clk); #1;
        total++; if (period_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL ena_valid got=%b want=0", period_valid_o); end
        total++; if (octave_o !== 2'b00) begin bad++; $display("[TB] FAIL ena_octave got=%b want=00", octave_o); end
        total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL ena_lock got=%b want=0", lock_o); end
        total++; if (silent_o !== 1'b0) begin bad++; $display("[TB] FAIL ena_silent got=%b want=0", silent_o); end
        total++; if (period_o !== 16'd100) begin bad++; $display("[TB] FAIL ena_period_hold got=%0d want=100", period_o); end
        repeat (20) @(negedge clk);
        tone_i = 1'b0;
        repeat (50) @(negedge clk);
        ena = 1'b1;
        clear_log();
        run_periods(100, 1);
        total++; if (vp_q.size() != 0) begin bad++; $display("[TB] FAIL ena_first_rise got=%0d want=0", vp_q.size()); end
        run_periods(100, 1);
        total++; if (vp_q.size() != 1) begin bad++; $display("[TB] FAIL ena_second_rise got=%0d want=1", vp_q.size()); end
        if (vp_q.size() >= 1) begin
            total++; if (vp_q[0] != 100) begin bad++; $display("[TB] FAIL ena_period got=%0d want=100", vp_q[0]); end
        end
        base_period = 16'd0;
        clear_log();
        run_periods(100, 2);
        run_periods(50, 2);
        run_periods(200, 2);
        total++; if (vp_q.size() != 6) begin bad++; $display("[TB] FAIL base0_pulses got=%0d want=6", vp_q.size()); end
        for (int i = 0; i < vp_q.size(); i++) begin
            total++; if (oc_q[i] !== 2'b00) begin bad++; $display("[TB] FAIL base0_octave idx=%0d got=%b want=00", i, oc_q[i]); end
        end
        base_period = 16'd100;
    endtask

    task automatic test_reset_mid();
        run_periods(100, 2);
        tone_i = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (period_o !== 16'd0) begin bad++; $display("[TB] FAIL rstmid_period got=%0d want=0", period_o); end
        total++; if (octave_o !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_octave got=%b want=00", octave_o); end
        total++; if (lock_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_lock got=%b want=0", lock_o); end
        tone_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        run_periods(100, 1);
        total++; if (vp_q.size() != 0) begin bad++; $display("[TB] FAIL rstmid_first_rise got=%0d want=0", vp_q.size()); end
        run_periods(100, 1);
        total++; if (vp_q.size() != 1) begin bad++; $display("[TB] FAIL rstmid_pulses got=%0d want=1", vp_q.size()); end
        if (vp_q.size() >= 1) begin
            total++; if (vp_q[0] != 100) begin bad++; $display("[TB] FAIL rstmid_period2 got=%0d want=100", vp_q[0]); end
            total++; if (lk_q[0] !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_lock2 got=%b want=0", lk_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_octaves();
        test_tolerance();
        test_silence();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
